wb_result_stage: RTL and testbench

WB_RESULT_STAGE -- requirements
Module: wb_result_stage

---
 rtl/wb_pkg.sv | 27 ++
 rtl/load_extend.sv | 46 ++++
 rtl/wb_result_stage.sv | 135 +++++++++++++
 tb/tb_wb_result_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback result stage: result-source selects,
// load size/sign codes and the stage state enum.
package wb_pkg;

    // Result source select
    localparam logic [1:0] RSRC_ALU  = 2'b00;
    localparam logic [1:0] RSRC_LOAD = 2'b01;
    localparam logic [1:0] RSRC_PC4  = 2'b10;
    localparam logic [1:0] RSRC_IMM  = 2'b11;

    // Load size/sign codes (Funct3)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Stage control states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WAIT_MEM = 2'b01,
        ST_OUT      = 2'b10
    } state_e;

endpackage

// File: rtl/load_extend.sv
// Combinational load data extraction: picks the byte/halfword/word at the
// byte offset inside an aligned memory word and sign- or zero-extends it.
// Illegal size codes (and 64-bit-only codes when XLEN=32) yield zero.
module load_extend
    import wb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OFFW = $clog2(XLEN / 8)
) (
    input  logic [2:0]      funct3,
    input  logic [OFFW-1:0] offset,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data
);

    logic [OFFW-1:0] off_h;
    logic [OFFW-1:0] off_w;
    logic [7:0]      lb;
    logic [15:0]     lh;
    logic [31:0]     lw;

    // Halfword and word accesses ignore the offset bits below their alignment.
    assign off_h = offset & ~OFFW'(1);
    assign off_w = offset & ~OFFW'(3);

    assign lb = rdata[{offset, 3'b000} +: 8];
    assign lh = rdata[{off_h, 3'b000} +: 16];
    assign lw = rdata[{off_w, 3'b000} +: 32];

    // Select and extend the field named by funct3.
    always_comb begin
        // NOTE: default assignment first so every path drives data and no latch is inferred.
        data = '0;
        case (funct3)
            F3_LB:  data = XLEN'($signed(lb));
            F3_LH:  data = XLEN'($signed(lh));
            F3_LW:  data = XLEN'($signed(lw));
            F3_LBU: data = XLEN'(lb);
            F3_LHU: data = XLEN'(lh);
            F3_LWU: if (XLEN == 64) data = XLEN'(lw);
            F3_LD:  if (XLEN == 64) data = rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/wb_result_stage.sv
// Writeback result stage: selects ALU / load / link / immediate value,
// waits for memory data when a load arrives ahead of it, and holds the
// registered Result under a valid/ready handshake toward the register file.
module wb_result_stage
    import wb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OFFW = $clog2(XLEN / 8)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ResultSrc,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] ALUResult,
    input  logic [XLEN-1:0] PCPlus4,
    input  logic [XLEN-1:0] ImmExt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] ReadData,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result
);

    state_e          state;
    state_e          state_n;
    logic            accept;
    logic            is_load;
    logic            load_pend;
    logic            wait_done;
    logic            capture;
    logic [2:0]      f3_q;
    logic [OFFW-1:0] off_q;
    logic [2:0]      ext_f3;
    logic [OFFW-1:0] ext_off;
    logic [XLEN-1:0] ext_data;
    logic [XLEN-1:0] result_d;

    assign accept    = in_valid && in_ready;
    assign is_load   = (ResultSrc == RSRC_LOAD);
    // A load accepted without its data parks in WAIT_MEM.
    assign load_pend = accept && is_load && !mem_rvalid;
    assign wait_done = (state == ST_WAIT_MEM) && mem_rvalid;
    assign capture   = (accept && !load_pend) || wait_done;

    // While waiting, extraction uses the size/offset captured at accept time.
    assign ext_f3  = (state == ST_WAIT_MEM) ? f3_q  : Funct3;
    assign ext_off = (state == ST_WAIT_MEM) ? off_q : ALUResult[OFFW-1:0];

    load_extend #(
        .XLEN (XLEN),
        .OFFW (OFFW)
    ) u_load_extend (
        .funct3 (ext_f3),
        .offset (ext_off),
        .rdata  (ReadData),
        .data   (ext_data)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Next-state logic; an accept in OUT chains the next request with no bubble.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_n = load_pend ? ST_WAIT_MEM : ST_OUT;
            end
            ST_WAIT_MEM: begin
                if (mem_rvalid) state_n = ST_OUT;
            end
            ST_OUT: begin
                if (accept)         state_n = load_pend ? ST_WAIT_MEM : ST_OUT;
                else if (out_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE:     in_ready = 1'b1;
            ST_WAIT_MEM: in_ready = 1'b0;
            ST_OUT: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Result source mux; undefined selects fall back to zero.
    always_comb begin
        result_d = '0;
        if (state == ST_WAIT_MEM) begin
            result_d = ext_data;
        end else begin
            case (ResultSrc)
                RSRC_ALU:  result_d = ALUResult;
                RSRC_LOAD: result_d = ext_data;
                RSRC_PC4:  result_d = PCPlus4;
                RSRC_IMM:  result_d = ImmExt;
                default:   result_d = '0;
            endcase
        end
    end

    // Result register and pending-load size/offset capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Result <= '0;
            f3_q   <= '0;
            off_q  <= '0;
        end else begin
            if (capture) Result <= result_d;
            if (load_pend) begin
                f3_q  <= Funct3;
                off_q <= ALUResult[OFFW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_wb_result_stage.sv
// Self-checking bench for wb_result_stage: table-driven single-request
// vectors on 32- and 64-bit instances, plus directed multi-cycle sequences
// for the delayed load, downstream stall, back-to-back and reset-drop cases.
module tb_wb_result_stage;

    typedef struct {
        logic [1:0]  rsrc;
        logic [2:0]  f3;
        logic [63:0] alu;
        logic [63:0] pc4;
        logic [63:0] imm;
        logic [63:0] rdata;
        logic        rvalid;
        logic [63:0] exp;
    } vec_t;

    logic clk;
    logic rst;

    // 32-bit instance signals
    logic        in_valid, in_ready, mem_rvalid, out_valid, out_ready;
    logic [1:0]  rsrc;
    logic [2:0]  f3;
    logic [31:0] alu, pc4, imm, rdata, result;

    // 64-bit instance signals
    logic        w_in_valid, w_in_ready, w_mem_rvalid, w_out_valid, w_out_ready;
    logic [1:0]  w_rsrc;
    logic [2:0]  w_f3;
    logic [63:0] w_alu, w_pc4, w_imm, w_rdata, w_result;

    int n_cmp = 0;
    int n_err = 0;

    vec_t v32 [17];
    vec_t v64 [8];

    wb_result_stage #(.XLEN(32)) dut32 (
        .clk (clk), .rst (rst),
        .in_valid (in_valid), .in_ready (in_ready),
        .ResultSrc (rsrc), .Funct3 (f3),
        .ALUResult (alu), .PCPlus4 (pc4), .ImmExt (imm),
        .mem_rvalid (mem_rvalid), .ReadData (rdata),
        .out_valid (out_valid), .out_ready (out_ready),
        .Result (result)
    );

    wb_result_stage #(.XLEN(64)) dut64 (
        .clk (clk), .rst (rst),
        .in_valid (w_in_valid), .in_ready (w_in_ready),
        .ResultSrc (w_rsrc), .Funct3 (w_f3),
        .ALUResult (w_alu), .PCPlus4 (w_pc4), .ImmExt (w_imm),
        .mem_rvalid (w_mem_rvalid), .ReadData (w_rdata),
        .out_valid (w_out_valid), .out_ready (w_out_ready),
        .Result (w_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge: present one request with out_ready=1, then
    // check the registered result just after the accepting rising edge.
    task automatic apply(input vec_t v, input bit wide, input int idx);
        string tag;
        tag = $sformatf("%s[%0d]", wide ? "v64" : "v32", idx);
        if (wide) begin
            w_in_valid = 1'b1; w_out_ready = 1'b1;
            w_rsrc = v.rsrc; w_f3 = v.f3; w_alu = v.alu; w_pc4 = v.pc4;
            w_imm = v.imm; w_rdata = v.rdata; w_mem_rvalid = v.rvalid;
            #1 check({tag, " in_ready"}, {63'b0, w_in_ready}, 64'd1);
        end else begin
            in_valid = 1'b1; out_ready = 1'b1;
            rsrc = v.rsrc; f3 = v.f3; alu = v.alu[31:0]; pc4 = v.pc4[31:0];
            imm = v.imm[31:0]; rdata = v.rdata[31:0]; mem_rvalid = v.rvalid;
            #1 check({tag, " in_ready"}, {63'b0, in_ready}, 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; mem_rvalid = 1'b0;
        w_in_valid = 1'b0; w_mem_rvalid = 1'b0;
        if (wide) begin
            check({tag, " out_valid"}, {63'b0, w_out_valid}, 64'd1);
            check({tag, " result"}, w_result, v.exp);
        end else begin
            check({tag, " out_valid"}, {63'b0, out_valid}, 64'd1);
            check({tag, " result"}, {32'b0, result}, v.exp);
        end
        @(negedge clk);
    endtask

    initial begin
        //              rsrc   f3      alu                     pc4             imm                     rdata                   rv    expected
        v32[0]  = '{2'b00, 3'b000, 64'h0000_1234, 64'h0, 64'h0, 64'h0, 1'b0, 64'h0000_1234};
        v32[1]  = '{2'b01, 3'b000, 64'h0000_0003, 64'h0, 64'h0, 64'h80AB_CDEF, 1'b1, 64'hFFFF_FF80};
        v32[2]  = '{2'b01, 3'b100, 64'h0000_0003, 64'h0, 64'h0, 64'h80AB_CDEF, 1'b1, 64'h0000_0080};
        v32[3]  = '{2'b10, 3'b000, 64'hDEAD_0001, 64'h0000_0100, 64'h0, 64'h0, 1'b0, 64'h0000_0100};
        v32[4]  = '{2'b11, 3'b000, 64'h0, 64'h0, 64'h1234_5000, 64'h0, 1'b0, 64'h1234_5000};
        v32[5]  = '{2'b01, 3'b000, 64'h0000_0000, 64'h0, 64'h0, 64'h80AB_CDEF, 1'b1, 64'hFFFF_FFEF};
        v32[6]  = '{2'b01, 3'b100, 64'h0000_0001, 64'h0, 64'h0, 64'h80AB_CDEF, 1'b1, 64'h0000_00CD};
        v32[7]  = '{2'b01, 3'b001, 64'h0000_0002, 64'h0, 64'h0, 64'h8001_0000, 1'b1, 64'hFFFF_8001};
        v32[8]  = '{2'b01, 3'b001, 64'h0000_0003, 64'h0, 64'h0, 64'h8001_0000, 1'b1, 64'hFFFF_8001};
        v32[9]  = '{2'b01, 3'b101, 64'h0000_0000, 64'h0, 64'h0, 64'h1234_F00D, 1'b1, 64'h0000_F00D};
        v32[10] = '{2'b01, 3'b001, 64'h0000_0000, 64'h0, 64'h0, 64'h1234_7FFF, 1'b1, 64'h0000_7FFF};
        v32[11] = '{2'b01, 3'b010, 64'h0000_0000, 64'h0, 64'h0, 64'h80AB_CDEF, 1'b1, 64'h80AB_CDEF};
        v32[12] = '{2'b01, 3'b010, 64'h0000_0003, 64'h0, 64'h0, 64'h80AB_CDEF, 1'b1, 64'h80AB_CDEF};
        v32[13] = '{2'b01, 3'b110, 64'h0000_0000, 64'h0, 64'h0, 64'h80AB_CDEF, 1'b1, 64'h0};
        v32[14] = '{2'b01, 3'b011, 64'h0000_0000, 64'h0, 64'h0, 64'h80AB_CDEF, 1'b1, 64'h0};
        v32[15] = '{2'b01, 3'b111, 64'h0000_0000, 64'h0, 64'h0, 64'h80AB_CDEF, 1'b1, 64'h0};
        v32[16] = '{2'b00, 3'b000, 64'hCAFE_BABE, 64'h0, 64'h0, 64'h0000_0001, 1'b1, 64'hCAFE_BABE};

        v64[0] = '{2'b01, 3'b110, 64'h4, 64'h0, 64'h0, 64'hDEAD_BEEF_0000_0001, 1'b1, 64'h0000_0000_DEAD_BEEF};
        v64[1] = '{2'b01, 3'b111, 64'h4, 64'h0, 64'h0, 64'hDEAD_BEEF_0000_0001, 1'b1, 64'h0};
        v64[2] = '{2'b01, 3'b011, 64'h0, 64'h0, 64'h0, 64'hDEAD_BEEF_0000_0001, 1'b1, 64'hDEAD_BEEF_0000_0001};
        v64[3] = '{2'b01, 3'b010, 64'h4, 64'h0, 64'h0, 64'hDEAD_BEEF_0000_0001, 1'b1, 64'hFFFF_FFFF_DEAD_BEEF};
        v64[4] = '{2'b01, 3'b000, 64'h7, 64'h0, 64'h0, 64'hDEAD_BEEF_0000_0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFDE};
        v64[5] = '{2'b01, 3'b101, 64'h6, 64'h0, 64'h0, 64'hDEAD_BEEF_0000_0001, 1'b1, 64'h0000_0000_0000_DEAD};
        v64[6] = '{2'b01, 3'b010, 64'h0, 64'h0, 64'h0, 64'hDEAD_BEEF_0000_0001, 1'b1, 64'h0000_0000_0000_0001};
        v64[7] = '{2'b00, 3'b000, 64'h1234_5678_9ABC_DEF0, 64'h0, 64'h0, 64'h0, 1'b1, 64'h1234_5678_9ABC_DEF0};

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; mem_rvalid = 1'b0;
        rsrc = '0; f3 = '0; alu = '0; pc4 = '0; imm = '0; rdata = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b1; w_mem_rvalid = 1'b0;
        w_rsrc = '0; w_f3 = '0; w_alu = '0; w_pc4 = '0; w_imm = '0; w_rdata = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset out_valid", {63'b0, out_valid}, 64'd0);
        check("reset result", {32'b0, result}, 64'd0);
        check("reset in_ready", {63'b0, in_ready}, 64'd1);
        check("reset result64", w_result, 64'd0);
        @(negedge clk);

        for (int i = 0; i < 17; i++) apply(v32[i], 1'b0, i);
        for (int i = 0; i < 8; i++)  apply(v64[i], 1'b1, i);

        // Delayed load: LH at offset 2, data arrives on the third cycle after accept.
        in_valid = 1'b1; out_ready = 1'b1;
        rsrc = 2'b01; f3 = 3'b001; alu = 32'h0000_0002; mem_rvalid = 1'b0;
        @(posedge clk);
        #1;
        // A competing request with different size/offset must not be taken.
        rsrc = 2'b00; f3 = 3'b000; alu = 32'h0000_0999;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("wait in_ready c%0d", i), {63'b0, in_ready}, 64'd0);
            check($sformatf("wait out_valid c%0d", i), {63'b0, out_valid}, 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; mem_rvalid = 1'b1; rdata = 32'h8001_0000;
        #1 check("wait in_ready rvalid", {63'b0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        check("delayed load out_valid", {63'b0, out_valid}, 64'd1);
        check("delayed load result", {32'b0, result}, 64'hFFFF_8001);
        @(negedge clk);
        @(negedge clk);

        // Downstream stall, then back-to-back results with no bubble.
        in_valid = 1'b1; out_ready = 1'b0; rsrc = 2'b00; alu = 32'h0000_0005;
        @(posedge clk);
        #1;
        rsrc = 2'b11; imm = 32'h1234_5000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("stall out_valid c%0d", i), {63'b0, out_valid}, 64'd1);
            check($sformatf("stall result c%0d", i), {32'b0, result}, 64'h5);
            check($sformatf("stall in_ready c%0d", i), {63'b0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        #1;
        check("release in_ready", {63'b0, in_ready}, 64'd1);
        check("release result held", {32'b0, result}, 64'h5);
        @(posedge clk);
        #1;
        check("b2b imm out_valid", {63'b0, out_valid}, 64'd1);
        check("b2b imm result", {32'b0, result}, 64'h1234_5000);
        rsrc = 2'b10; pc4 = 32'h0000_0044;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b pc4 out_valid", {63'b0, out_valid}, 64'd1);
        check("b2b pc4 result", {32'b0, result}, 64'h44);
        @(posedge clk);
        #1;
        check("drain out_valid", {63'b0, out_valid}, 64'd0);
        @(negedge clk);

        // Reset in WAIT_MEM drops the load; a stray mem_rvalid is ignored.
        in_valid = 1'b1; rsrc = 2'b01; f3 = 3'b010; alu = 32'h0; mem_rvalid = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("pre-reset in_ready", {63'b0, in_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async reset result", {32'b0, result}, 64'd0);
        check("async reset out_valid", {63'b0, out_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1; rdata = 32'h1357_9BDF;
        #1 check("post-reset in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        check("stray rvalid out_valid", {63'b0, out_valid}, 64'd0);
        check("stray rvalid result", {32'b0, result}, 64'd0);
        check("stray rvalid in_ready", {63'b0, in_ready}, 64'd1);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
